// File: rtl/upsize_pair_arbiter.sv
// rtl/upsize_pair_arbiter.sv - round-robin arbiter locking each grant for BEATS beats
// Feeds a 2:1 upsizer so both halves of an upsized word come from one requester.
module upsize_pair_arbiter #(
  parameter  int N     = 4,
  parameter  int W     = 5,
  parameter  int BEATS = 2,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [N*W-1:0]  in_tdata,
  input  logic [N-1:0]    in_tvalid,
  output logic [N-1:0]    in_tready,
  output logic [W-1:0]    out_tdata,
  output logic [IW-1:0]   out_tid,
  output logic            out_tlast,
  output logic            out_tvalid,
  input  logic            out_tready
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]   winner;
  logic            any_valid;
  logic            last_beat;
  logic            handshake;
  int              idx;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    winner    = ptr_q;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!any_valid && in_tvalid[idx]) begin
        any_valid = 1'b1;
        winner    = IW'(idx);
      end
    end
  end

  assign last_beat = (cnt_q == CW'(BEATS - 1));
  assign handshake = out_tvalid & out_tready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    out_tid    = '0;
    in_tready  = '0;
    out_tdata  = in_tdata[int'(grant_q)*W +: W];
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        out_tvalid         = in_tvalid[grant_q];
        out_tlast          = last_beat;
        out_tid            = grant_q;
        in_tready[grant_q] = out_tready;
        if (handshake) begin
          if (last_beat) begin
            ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  a_valid_only_locked: assert property (@(posedge aclk) disable iff (!aresetn)
    out_tvalid |-> state_q == LOCKED);
  a_ready_onehot0: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(in_tready));

endmodule

// File: tb/tb_upsize_pair_arbiter.sv
// tb/tb_upsize_pair_arbiter.sv - randomized and directed checks against a behavioural model
module tb_upsize_pair_arbiter;
  localparam int N     = 4;
  localparam int W     = 5;
  localparam int BEATS = 2;
  localparam int IW    = 2;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N*W-1:0]  in_tdata = '0;
  logic [N-1:0]    in_tvalid = '0;
  logic [N-1:0]    in_tready;
  logic [W-1:0]    out_tdata;
  logic [IW-1:0]   out_tid;
  logic            out_tlast;
  logic            out_tvalid;
  logic            out_tready = 1'b0;

  upsize_pair_arbiter #(.N(N), .W(W), .BEATS(BEATS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tid(out_tid), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester sources: one FIFO of pending words each, plus a valid mask.
  int fifo [N][64];
  int hd [N];
  int tl [N];
  logic [N-1:0] mask = '1;

  task automatic push(int i, int d);
    fifo[i][tl[i] % 64] = d;
    tl[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_tvalid[i] = (tl[i] != hd[i]) && mask[i];
      if (tl[i] != hd[i]) in_tdata[i*W +: W] = W'(fifo[i][hd[i] % 64]);
      else                in_tdata[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic step();
    logic [N-1:0] hs;
    @(negedge aclk);
    hs = in_tready & in_tvalid;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) hd[i]++;
    drive();
  endtask

  // Behavioural model: who owns the stream, how many beats it has sent, rotation pointer.
  int m_owner = -1;
  int m_beat = 0;
  int m_ptr = 0;
  int acc_tid[$];
  int acc_data[$];
  int acc_last[$];
  int acc_cyc[$];

  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      m_owner = -1; m_beat = 0; m_ptr = 0;
      chk("rst_tvalid", 32'(out_tvalid), 0);
      chk("rst_tready", 32'(in_tready), 0);
      chk("rst_tlast", 32'(out_tlast), 0);
      chk("rst_tid", 32'(out_tid), 0);
    end else begin
      logic             e_valid;
      logic [N-1:0]     e_ready;
      e_valid = (m_owner >= 0) ? in_tvalid[m_owner] : 1'b0;
      e_ready = (m_owner >= 0) ? (N'(out_tready) << m_owner) : '0;
      chk("tvalid", 32'(out_tvalid), 32'(e_valid));
      chk("tready", 32'(in_tready), 32'(e_ready));
      if (e_valid) begin
        chk("tdata", 32'(out_tdata), 32'(in_tdata[m_owner*W +: W]));
        chk("tid", 32'(out_tid), 32'(m_owner));
        chk("tlast", 32'(out_tlast), 32'(m_beat == BEATS - 1));
      end
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && in_tvalid[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_beat  = 0;
          end
        end
      end else if (e_valid && out_tready) begin
        acc_tid.push_back(m_owner);
        acc_data.push_back(int'(in_tdata[m_owner*W +: W]));
        acc_last.push_back(int'(m_beat == BEATS - 1));
        acc_cyc.push_back(cyc);
        m_beat++;
        if (m_beat == BEATS) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_beat  = 0;
        end
      end
    end
  end

  task automatic clear_acc();
    acc_tid.delete(); acc_data.delete(); acc_last.delete(); acc_cyc.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    out_tready = 1'b0;
    mask = '1;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    drive();
    repeat (2) @(posedge aclk);
    #1;
    clear_acc();
    aresetn = 1'b1;
  endtask

  task automatic wait_acc(int n, string name);
    int budget;
    budget = 200;
    while (acc_tid.size() < n && budget > 0) begin step(); budget--; end
    if (acc_tid.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d beats expected %0d", name, acc_tid.size(), n);
    end
  endtask

  task automatic chk_beat(string name, int k, int tid, int data, int last);
    if (k >= acc_tid.size()) begin
      checks++; errors++;
      $display("FAIL %s_missing: got %0d beats expected beat %0d", name, acc_tid.size(), k);
    end else begin
      chk({name, "_tid"}, acc_tid[k], tid);
      chk({name, "_data"}, acc_data[k], data);
      chk({name, "_last"}, acc_last[k], last);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    drive();

    // 1: single requester, one idle cycle between groups
    do_reset();
    for (int d = 1; d <= 4; d++) push(0, d);
    out_tready = 1'b1; drive();
    wait_acc(4, "t1");
    chk_beat("t1b0", 0, 0, 1, 0);
    chk_beat("t1b1", 1, 0, 2, 1);
    chk_beat("t1b2", 2, 0, 3, 0);
    chk_beat("t1b3", 3, 0, 4, 1);
    if (acc_cyc.size() >= 4) begin
      chk("t1_intra_gap", acc_cyc[1] - acc_cyc[0], 1);
      chk("t1_inter_gap", acc_cyc[2] - acc_cyc[1], 2);
    end

    // 2: all requesters busy, rotation 0,1,2,3,0 with 3-cycle group period
    do_reset();
    for (int i = 0; i < N; i++) for (int d = 0; d < 10; d++) push(i, i * 8 + d);
    out_tready = 1'b1; drive();
    wait_acc(10, "t2");
    for (int k = 0; k < 10 && k < acc_tid.size(); k++) chk("t2_order", acc_tid[k], (k / 2) % 4);
    if (acc_cyc.size() >= 10) begin
      chk("t2_period", acc_cyc[2] - acc_cyc[0], 3);
      chk("t2_span", acc_cyc[8] - acc_cyc[0], 12);
    end

    // 3: owner stalls mid-group, other requester must wait
    do_reset();
    push(2, 'h0A);
    out_tready = 1'b1; drive();
    wait_acc(1, "t3a");
    push(1, 'h11); push(1, 'h12); drive();
    repeat (4) step();
    chk("t3_no_steal", acc_tid.size(), 1);
    push(2, 'h0B); drive();
    wait_acc(4, "t3b");
    chk_beat("t3b0", 0, 2, 'h0A, 0);
    chk_beat("t3b1", 1, 2, 'h0B, 1);
    chk_beat("t3b2", 2, 1, 'h11, 0);
    chk_beat("t3b3", 3, 1, 'h12, 1);

    // 4: downstream backpressure mid-group keeps outputs stable
    do_reset();
    push(0, 5); push(0, 6);
    out_tready = 1'b1; drive();
    wait_acc(1, "t4a");
    out_tready = 1'b0;
    repeat (3) begin
      step();
      chk("t4_tvalid", 32'(out_tvalid), 1);
      chk("t4_tdata", 32'(out_tdata), 6);
      chk("t4_tid", 32'(out_tid), 0);
      chk("t4_tlast", 32'(out_tlast), 1);
      chk("t4_tready", 32'(in_tready), 0);
    end
    out_tready = 1'b1;
    wait_acc(2, "t4b");
    chk_beat("t4b1", 1, 0, 6, 1);

    // 5: reset mid-group abandons it; pointer restarts at 0
    do_reset();
    push(3, 'h13); push(3, 'h14);
    out_tready = 1'b1; drive();
    wait_acc(1, "t5a");
    chk_beat("t5b0", 0, 3, 'h13, 0);
    aresetn = 1'b0;
    #1;
    chk("t5_async_tvalid", 32'(out_tvalid), 0);
    chk("t5_async_tready", 32'(in_tready), 0);
    chk("t5_async_tid", 32'(out_tid), 0);
    push(0, 1); push(0, 2); push(3, 'h15); drive();
    repeat (2) @(posedge aclk);
    #1;
    clear_acc();
    aresetn = 1'b1;
    wait_acc(4, "t5b");
    chk_beat("t5c0", 0, 0, 1, 0);
    chk_beat("t5c1", 1, 0, 2, 1);
    chk_beat("t5c2", 2, 3, 'h14, 0);
    chk_beat("t5c3", 3, 3, 'h15, 1);

    // 6: wrap search from ptr=3 to req1, then ptr=2 prefers req2
    do_reset();
    push(2, 7); push(2, 8);
    out_tready = 1'b1; drive();
    wait_acc(2, "t6a");
    push(1, 3); push(1, 4); drive();
    wait_acc(4, "t6b");
    chk_beat("t6b2", 2, 1, 3, 0);
    push(0, 20); push(0, 21); push(1, 22); push(1, 23); push(2, 24); push(2, 25); drive();
    wait_acc(10, "t6c");
    chk_beat("t6c4", 4, 2, 24, 0);
    chk_beat("t6c6", 6, 0, 20, 0);
    chk_beat("t6c8", 8, 1, 22, 0);

    // Randomized traffic with valid drops, backpressure and one reset mid-run
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0 && (tl[i] - hd[i]) < 40) push(i, int'($urandom_range(31)));
      for (int i = 0; i < N; i++) mask[i] = ($urandom_range(3) != 0);
      out_tready = ($urandom_range(2) != 0);
      if (it == 1500) aresetn = 1'b0;
      if (it == 1503) aresetn = 1'b1;
      drive();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
